// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one SRAM fetch per cycle, buffers the returned
// word while ID is stalled, and redirects immediately on a flush from ID.
module if_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_if_ready,
    input  logic        i_id_allow_in,
    output logic [31:0] o_inst_from_if,
    output logic [31:0] o_pc_from_if,
    input  logic        i_flush,
    input  logic [31:0] i_newpc,
    output logic        o_inst_sram_en,
    output logic [3:0]  o_inst_sram_we,
    output logic [31:0] o_inst_sram_addr,
    output logic [31:0] o_inst_sram_wdata,
    input  logic [31:0] i_inst_sram_rdata
);

    localparam logic [31:0] RESET_PC = 32'h1BFF_FFFC;

    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic        r_buf_valid;
    logic [31:0] r_buf_inst;

    logic        w_fs_allowin;
    logic [31:0] w_nextpc;

    // A flush always opens the stage so the redirect fetch goes out in the same cycle.
    assign w_fs_allowin = ~r_fs_valid | (o_if_ready & i_id_allow_in) | i_flush;
    assign w_nextpc     = i_flush ? i_newpc : r_fs_pc + 32'd4;

    assign o_inst_sram_en    = w_fs_allowin & ~i_reset;
    assign o_inst_sram_addr  = w_nextpc;
    assign o_inst_sram_we    = 4'b0000;
    assign o_inst_sram_wdata = 32'b0;

    assign o_if_ready     = r_fs_valid & ~i_flush;
    assign o_inst_from_if = r_buf_valid ? r_buf_inst : i_inst_sram_rdata;
    assign o_pc_from_if   = r_fs_pc;

    // The SRAM only holds its read data for one cycle, so the word is captured on the first stalled edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fs_valid  <= 1'b0;
            r_fs_pc     <= RESET_PC;
            r_buf_valid <= 1'b0;
            r_buf_inst  <= 32'b0;
        end else if (o_inst_sram_en) begin
            r_fs_valid  <= 1'b1;
            r_fs_pc     <= w_nextpc;
            r_buf_valid <= 1'b0;
        end else if (r_fs_valid && !r_buf_valid) begin
            r_buf_inst  <= i_inst_sram_rdata;
            r_buf_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random traffic,
// compared against an instruction-level model of what IF should present to ID.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifReady;
    logic        idAllowIn;
    logic [31:0] instFromIf;
    logic [31:0] pcFromIf;
    logic        flush;
    logic [31:0] newpc;
    logic        sramEn;
    logic [3:0]  sramWe;
    logic [31:0] sramAddr;
    logic [31:0] sramWdata;
    logic [31:0] sramRdata;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] memKey;
    logic [31:0] delivered[$];
    logic [31:0] stallInst;

    // Model: whether IF holds an instruction, and its PC; the word itself is always memWord(pc).
    bit          mHave;
    logic [31:0] mPc;
    bit          expReady;
    bit          expEn;
    logic [31:0] expAddr;

    if_stage dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .o_if_ready        (ifReady),
        .i_id_allow_in     (idAllowIn),
        .o_inst_from_if    (instFromIf),
        .o_pc_from_if      (pcFromIf),
        .i_flush           (flush),
        .i_newpc           (newpc),
        .o_inst_sram_en    (sramEn),
        .o_inst_sram_we    (sramWe),
        .o_inst_sram_addr  (sramAddr),
        .o_inst_sram_wdata (sramWdata),
        .i_inst_sram_rdata (sramRdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ memKey;
    endfunction

    // Memory returns the addressed word one cycle after a request, and garbage otherwise.
    always @(posedge clk) begin
        if (sramEn === 1'b1)
            sramRdata <= memWord(sramAddr);
        else
            sramRdata <= $urandom;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int countDelivered(input logic [31:0] pc);
        int n = 0;
        foreach (delivered[i])
            if (delivered[i] == pc) n++;
        return n;
    endfunction

    task automatic applyStimulus(input bit rst, input bit allow, input bit fl, input logic [31:0] np);
        reset     = rst;
        idAllowIn = allow;
        flush     = fl;
        newpc     = np;
        expReady  = mHave && !fl;
        expEn     = (!mHave || (expReady && allow) || fl) && !rst;
        expAddr   = fl ? np : mPc + 32'd4;
        @(negedge clk);
        checkOutput("if_ready", {31'b0, ifReady}, {31'b0, expReady});
        checkOutput("pc_from_if", pcFromIf, mPc);
        checkOutput("sram_en", {31'b0, sramEn}, {31'b0, expEn});
        checkOutput("sram_we", {28'b0, sramWe}, 32'b0);
        checkOutput("sram_wdata", sramWdata, 32'b0);
        if (expEn)
            checkOutput("sram_addr", sramAddr, expAddr);
        if (expReady)
            checkOutput("inst_from_if", instFromIf, memWord(mPc));
        if (ifReady === 1'b1 && allow)
            delivered.push_back(pcFromIf);
    endtask

    task automatic nextEdge();
        @(posedge clk);
        if (reset) begin
            mHave = 1'b0;
            mPc   = 32'h1BFF_FFFC;
        end else if (expEn) begin
            mHave = 1'b1;
            mPc   = expAddr;
        end
        #1;
    endtask

    task automatic step(input bit rst, input bit allow, input bit fl, input logic [31:0] np);
        applyStimulus(rst, allow, fl, np);
        nextEdge();
    endtask

    initial begin
        memKey    = $urandom;
        sramRdata = 32'b0;
        reset     = 1'b1;
        idAllowIn = 1'b0;
        flush     = 1'b0;
        newpc     = 32'b0;
        mHave     = 1'b0;
        mPc       = 32'h1BFF_FFFC;
        @(posedge clk);
        #1;

        applyStimulus(1, 0, 0, 0);
        checkOutput("reset_pc", pcFromIf, 32'h1BFF_FFFC);
        checkOutput("reset_en", {31'b0, sramEn}, 32'd0);
        nextEdge();

        // Reset release with ID always accepting.
        applyStimulus(0, 1, 0, 0);
        checkOutput("first_addr", sramAddr, 32'h1C00_0000);
        nextEdge();
        applyStimulus(0, 1, 0, 0);
        checkOutput("second_addr", sramAddr, 32'h1C00_0004);
        checkOutput("first_ready", {31'b0, ifReady}, 32'd1);
        nextEdge();
        applyStimulus(0, 1, 0, 0);
        checkOutput("third_addr", sramAddr, 32'h1C00_0008);
        nextEdge();

        // Three-cycle stall on 1C000008; read data turns to garbage after the first.
        applyStimulus(0, 0, 0, 0);
        checkOutput("stall_pc", pcFromIf, 32'h1C00_0008);
        stallInst = instFromIf;
        nextEdge();
        applyStimulus(0, 0, 0, 0);
        checkOutput("stall_hold1", instFromIf, stallInst);
        nextEdge();
        applyStimulus(0, 0, 0, 0);
        checkOutput("stall_hold2", instFromIf, stallInst);
        nextEdge();
        applyStimulus(0, 1, 0, 0);
        checkOutput("stall_release_inst", instFromIf, stallInst);
        checkOutput("stall_release_addr", sramAddr, 32'h1C00_000C);
        nextEdge();
        step(0, 1, 0, 0);

        // Single-cycle flush while 1C000010 sits in IF.
        applyStimulus(0, 1, 1, 32'h1C00_0100);
        checkOutput("flush_pc", pcFromIf, 32'h1C00_0010);
        checkOutput("flush_ready", {31'b0, ifReady}, 32'd0);
        nextEdge();
        applyStimulus(0, 1, 0, 0);
        checkOutput("redirect_pc", pcFromIf, 32'h1C00_0100);
        nextEdge();

        // Flush held two cycles with ID not accepting.
        applyStimulus(0, 0, 1, 32'h1C00_0200);
        checkOutput("held_flush_addr1", sramAddr, 32'h1C00_0200);
        nextEdge();
        applyStimulus(0, 0, 1, 32'h1C00_0200);
        checkOutput("held_flush_addr2", sramAddr, 32'h1C00_0200);
        nextEdge();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        checkOutput("deliver_1C000200_once", countDelivered(32'h1C00_0200), 32'd1);
        checkOutput("never_1C000010", countDelivered(32'h1C00_0010), 32'd0);
        checkOutput("deliver_1C000008_once", countDelivered(32'h1C00_0008), 32'd1);

        // Flush while the stall buffer holds a word.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h1C00_0300);
        applyStimulus(0, 1, 0, 0);
        checkOutput("buf_flush_inst", instFromIf, memWord(32'h1C00_0300));
        nextEdge();

        // Address wrap-around.
        step(0, 1, 1, 32'hFFFF_FFF8);
        step(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("wrap_pc", pcFromIf, 32'hFFFF_FFFC);
        checkOutput("wrap_addr", sramAddr, 32'h0000_0000);
        nextEdge();
        step(0, 1, 0, 0);

        // Misaligned redirect passes straight through.
        step(0, 1, 1, 32'h1C00_0402);
        applyStimulus(0, 1, 0, 0);
        checkOutput("misaligned_addr", sramAddr, 32'h1C00_0406);
        nextEdge();

        // Reset in the middle of a buffered stall.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("post_reset_ready", {31'b0, ifReady}, 32'd0);
        checkOutput("post_reset_addr", sramAddr, 32'h1C00_0000);
        nextEdge();

        // Reset in the middle of a flush.
        step(0, 1, 0, 0);
        applyStimulus(1, 1, 1, 32'h1C00_0500);
        checkOutput("reset_flush_en", {31'b0, sramEn}, 32'd0);
        nextEdge();
        applyStimulus(0, 1, 0, 0);
        checkOutput("reset_flush_addr", sramAddr, 32'h1C00_0000);
        nextEdge();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 65),
                 ($urandom_range(0, 99) < 12),
                 $urandom);
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_ready  output  1  IF holds a valid, deliverable instruction for ID.
REQ-005 id_allow_in  input  1  ID can accept an instruction this cycle.
REQ-006 inst_from_if  output  32  instruction word presented to ID.
REQ-007 pc_from_if  output  32  PC of inst_from_if.
REQ-008 flush  input  1  redirect request from ID; combinational, may be held for several cycles.
REQ-009 newpc  input  32  redirect target; valid while flush=1.
REQ-010 inst_sram_en  output  1  fetch request strobe.
REQ-011 inst_sram_we  output  4  write enables; constant 4'b0000.
REQ-012 inst_sram_addr  output  32  fetch address.
REQ-013 inst_sram_wdata  output  32  write data; constant 32'b0.
REQ-014 inst_sram_rdata  input  32  read data; valid exactly one cycle after the cycle in which en=1 was sampled with that address.

Function
REQ-015 Internal state SHALL be: fs_valid (1), fs_pc (32), buf_valid (1), buf_inst (32).
REQ-016 fs_allowin = ~fs_valid | (if_ready & id_allow_in) | flush.
REQ-017 nextpc = flush ? newpc : fs_pc + 4 (32-bit, wraps modulo 2^32, no carry out).
REQ-018 inst_sram_en = fs_allowin & ~reset; inst_sram_addr = nextpc (combinational).
REQ-019 When inst_sram_en=1 at a clock edge: fs_valid<=1, fs_pc<=nextpc, buf_valid<=0.
REQ-020 if_ready = fs_valid & ~flush; an instruction SHALL never be delivered to ID in a cycle where flush=1.
REQ-021 inst_from_if = buf_valid ? buf_inst : inst_sram_rdata; pc_from_if = fs_pc.
REQ-022 Stall capture: when fs_valid=1, fs_allowin=0 and buf_valid=0, buf_inst<=inst_sram_rdata and buf_valid<=1 at the edge.
REQ-023 While stalled with buf_valid=1, buf_inst, fs_pc and inst_from_if SHALL stay constant; no new SRAM request is issued.
REQ-024 Handshake: the IF->ID transfer occurs exactly when if_ready & id_allow_in = 1; that same edge loads the next fetch (REQ-019), giving one instruction per cycle when unstalled.
REQ-025 Flush: at any edge with flush=1, the current IF instruction (buffered or not) SHALL be discarded, and fs_pc<=newpc with buf_valid<=0.
REQ-026 Held flush: each cycle flush stays 1 re-fetches newpc; the result is idempotent, and the first cycle after flush drops delivers newpc's instruction.
REQ-027 Simultaneous flush and id_allow_in=1: no transfer (if_ready=0); the redirect fetch is issued.
REQ-028 Fetch latency SHALL be one cycle from address issue to if_ready=1, absent flush.
REQ-029 PC alignment SHALL NOT be checked; misaligned addresses pass through unchanged (exceptions out of scope).

Reset
REQ-030 During reset: fs_valid=0, buf_valid=0, buf_inst=0, fs_pc=32'h1BFF_FFFC, inst_sram_en=0.
REQ-031 Consequently during reset: if_ready=0, pc_from_if=32'h1BFF_FFFC, inst_sram_we=0, inst_sram_wdata=0.
REQ-032 In the first cycle after reset deasserts, inst_sram_en=1 with inst_sram_addr=32'h1C00_0000.
REQ-033 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state at that edge.

Verification
REQ-034 Reset release, id_allow_in=1 constant -> addr 1C000000, 1C000004, 1C000008 on consecutive cycles; pc_from_if trails addr by one cycle; if_ready=1 from the second cycle onward.
REQ-035 Hold id_allow_in=0 for 3 cycles with fs_pc=1C000008 and rdata changing after the first stall cycle -> inst_from_if stays equal to the first-cycle rdata; inst_sram_en=0 throughout the stall; on release, 1C000008 transfers once and the next addr is 1C00000C.
REQ-036 Pulse flush=1 with newpc=1C000100 while fs_pc=1C000010 -> if_ready=0 that cycle; next cycle pc_from_if=1C000100, if_ready=1; 1C000010 is never transferred.
REQ-037 flush=1 held 2 cycles with id_allow_in=0, newpc=1C000200 -> addr=1C000200 both cycles; after flush drops, exactly one delivery of pc 1C000200.
REQ-038 Flush during a buffered stall (buf_valid=1) -> buffer is discarded and the next delivered instruction is the rdata fetched for newpc.
REQ-039 fs_pc=FFFFFFFC, unstalled -> next addr=00000000 (wrap-around).
